// File: rtl/program_bus_arbiter_pkg.sv
// Shared types for the program-ROM port arbiter: FSM state encoding and access owner tags.
package program_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_FETCH = 1'b0,
        OWNER_LD    = 1'b1
    } owner_t;

    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/program_bus_arbiter_rr_starve_guard.sv
// Grant selection between fetch and load: load wins by default, but fetch is forced
// through once MAX_LD_RUN loads in a row have been granted while fetch was waiting.
module rr_starve_guard #(
    parameter int MAX_LD_RUN = 4,
    parameter int RUN_W      = $clog2(MAX_LD_RUN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             accept,
    input  logic             fetch_req,
    input  logic             ld_req,
    output logic             fetch_gnt,
    output logic             ld_gnt,
    output logic [RUN_W-1:0] ld_run
);

    logic [RUN_W-1:0] ld_run_q;
    logic [RUN_W-1:0] ld_run_d;
    logic             at_limit;
    logic             fetch_wins;

    always_comb begin
        at_limit   = (ld_run_q == RUN_W'(MAX_LD_RUN));
        fetch_wins = fetch_req && (!ld_req || at_limit);
        fetch_gnt  = accept && fetch_wins;
        ld_gnt     = accept && ld_req && !fetch_wins;

        // The run only measures loads that overtook a waiting fetch.
        ld_run_d = ld_run_q;
        if (!fetch_req || fetch_gnt) begin
            ld_run_d = '0;
        end else if (ld_gnt && !at_limit) begin
            ld_run_d = ld_run_q + RUN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_run_q <= '0;
        end else begin
            ld_run_q <= ld_run_d;
        end
    end

    assign ld_run = ld_run_q;

endmodule

// File: rtl/program_bus_arbiter.sv
// Shares the program-ROM port between instruction fetch and data loads, sequencing
// each access through WAIT_STATES ROM wait cycles and returning data with a valid pulse.
module program_bus_arbiter
    import program_bus_arbiter_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                WAIT_STATES = 0,
    parameter int                MAX_LD_RUN  = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               fetch_req,
    input  logic [ADDR_W-1:0]                  fetch_addr,
    output logic                               fetch_gnt,
    output logic                               fetch_valid,
    output logic [DATA_W-1:0]                  fetch_rdata,
    input  logic                               ld_req,
    input  logic [ADDR_W-1:0]                  ld_addr,
    output logic                               ld_gnt,
    output logic                               ld_valid,
    output logic [DATA_W-1:0]                  ld_rdata,
    output logic [ADDR_W-1:0]                  program_addr_bus,
    input  logic [DATA_W-1:0]                  program_data_bus,
    output logic                               busy,
    output state_t                             dbg_state,
    output logic [$clog2(MAX_LD_RUN+1)-1:0]    dbg_ld_run
);

    state_t                  state_q, state_d;
    owner_t                  owner_q, owner_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       fetch_rdata_q, fetch_rdata_d;
    logic [DATA_W-1:0]       ld_rdata_q, ld_rdata_d;
    logic                    fetch_valid_q, fetch_valid_d;
    logic                    ld_valid_q, ld_valid_d;
    logic                    accept;

    // IDLE and CAPTURE are both accept slots, which gives back-to-back throughput.
    assign accept = (state_q == ST_IDLE) || (state_q == ST_CAPTURE);

    rr_starve_guard #(
        .MAX_LD_RUN (MAX_LD_RUN)
    ) u_guard (
        .clk       (clk),
        .reset     (reset),
        .accept    (accept),
        .fetch_req (fetch_req),
        .ld_req    (ld_req),
        .fetch_gnt (fetch_gnt),
        .ld_gnt    (ld_gnt),
        .ld_run    (dbg_ld_run)
    );

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        fetch_rdata_d = fetch_rdata_q;
        ld_rdata_d    = ld_rdata_q;
        fetch_valid_d = 1'b0;
        ld_valid_d    = 1'b0;

        case (state_q)
            ST_WAIT: begin
                cnt_d = cnt_q - WAIT_CNT_W'(1);
                if (cnt_q == WAIT_CNT_W'(1)) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (owner_q == OWNER_FETCH) begin
                    fetch_rdata_d = program_data_bus;
                    fetch_valid_d = 1'b1;
                end else begin
                    ld_rdata_d = program_data_bus;
                    ld_valid_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A grant overrides the fall-back to IDLE and starts the next access.
        if (fetch_gnt || ld_gnt) begin
            addr_d  = fetch_gnt ? fetch_addr : ld_addr;
            owner_d = fetch_gnt ? OWNER_FETCH : OWNER_LD;
            cnt_d   = WAIT_CNT_W'(WAIT_STATES);
            state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_CAPTURE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWNER_FETCH;
            cnt_q         <= '0;
            addr_q        <= RESET_ADDR;
            fetch_rdata_q <= '0;
            ld_rdata_q    <= '0;
            fetch_valid_q <= 1'b0;
            ld_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            fetch_rdata_q <= fetch_rdata_d;
            ld_rdata_q    <= ld_rdata_d;
            fetch_valid_q <= fetch_valid_d;
            ld_valid_q    <= ld_valid_d;
        end
    end

    assign program_addr_bus = addr_q;
    assign fetch_rdata      = fetch_rdata_q;
    assign ld_rdata         = ld_rdata_q;
    assign fetch_valid      = fetch_valid_q;
    assign ld_valid         = ld_valid_q;
    assign busy             = (state_q != ST_IDLE);
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_program_bus_arbiter.sv
// Bench for program_bus_arbiter: a zero-wait-state instance driven from a vector table and
// a two-wait-state instance driven by hand sequences and a random run against a reference model.
module tb_program_bus_arbiter;
    import program_bus_arbiter_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int WS_A = 0;
    localparam int WS_B = 2;
    localparam int MAXR = 4;
    localparam int RW   = $clog2(MAXR + 1);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [DW-1:0] rom [64];

    logic          a_freq, a_lreq, a_fg, a_lg, a_fv, a_lv, a_busy;
    logic [AW-1:0] a_faddr, a_laddr, a_pab;
    logic [DW-1:0] a_pdb, a_frd, a_lrd;
    state_t        a_st;
    logic [RW-1:0] a_run;

    logic          b_freq, b_lreq, b_fg, b_lg, b_fv, b_lv, b_busy;
    logic [AW-1:0] b_faddr, b_laddr, b_pab;
    logic [DW-1:0] b_pdb, b_frd, b_lrd;
    state_t        b_st;
    logic [RW-1:0] b_run;

    assign a_pdb = rom[a_pab[7:2]];
    assign b_pdb = rom[b_pab[7:2]];

    program_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS_A), .MAX_LD_RUN(MAXR)) u_dut_a (
        .clk(clk), .reset(reset),
        .fetch_req(a_freq), .fetch_addr(a_faddr), .fetch_gnt(a_fg), .fetch_valid(a_fv), .fetch_rdata(a_frd),
        .ld_req(a_lreq), .ld_addr(a_laddr), .ld_gnt(a_lg), .ld_valid(a_lv), .ld_rdata(a_lrd),
        .program_addr_bus(a_pab), .program_data_bus(a_pdb), .busy(a_busy),
        .dbg_state(a_st), .dbg_ld_run(a_run)
    );

    program_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS_B), .MAX_LD_RUN(MAXR)) u_dut_b (
        .clk(clk), .reset(reset),
        .fetch_req(b_freq), .fetch_addr(b_faddr), .fetch_gnt(b_fg), .fetch_valid(b_fv), .fetch_rdata(b_frd),
        .ld_req(b_lreq), .ld_addr(b_laddr), .ld_gnt(b_lg), .ld_valid(b_lv), .ld_rdata(b_lrd),
        .program_addr_bus(b_pab), .program_data_bus(b_pdb), .busy(b_busy),
        .dbg_state(b_st), .dbg_ld_run(b_run)
    );

    typedef struct {
        logic          freq;
        logic [AW-1:0] faddr;
        logic          lreq;
        logic [AW-1:0] laddr;
        logic          exp_fg;
        logic          exp_lg;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t          vecs[7];
    logic [DW:0]   exp_q[$];
    int            due_q[$];
    int            total = 0;
    int            bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rom_at(input logic [AW-1:0] a);
        return rom[a[7:2]];
    endfunction

    task automatic b_idle(input int n);
        b_freq = 1'b0;
        b_lreq = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] lf, ll;
        logic [DW:0]   ent;
        logic          efg, elg, efv, elv, busy_e, allowed, fg_seen, lg_seen, quiet;
        int            ng, nv, run, last_g;

        reset = 1'b0;
        a_freq = 1'b0; a_lreq = 1'b0; a_faddr = '0; a_laddr = '0;
        b_freq = 1'b0; b_lreq = 1'b0; b_faddr = '0; b_laddr = '0;
        for (int i = 0; i < 64; i++) rom[i] = $urandom;
        rom[4] = 32'h00500093;

        vecs[0] = '{1'b1, 32'h0000_0010, 1'b0, 32'h0,         1'b1, 1'b0, 32'h00500093};
        vecs[1] = '{1'b0, 32'h0,         1'b1, 32'h0000_0020, 1'b0, 1'b1, 32'h0};
        vecs[2] = '{1'b1, 32'h0000_0004, 1'b1, 32'h0000_0008, 1'b0, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 32'h0000_0030, 1'b0, 32'h0000_0034, 1'b0, 1'b0, 32'h0};
        vecs[4] = '{1'b1, 32'hABCD_00FC, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0};
        vecs[5] = '{1'b1, 32'h0000_0040, 1'b1, 32'h0000_0044, 1'b0, 1'b1, 32'h0};
        vecs[6] = '{1'b0, 32'h0,         1'b1, 32'h1000_0000, 1'b0, 1'b1, 32'h0};
        for (int i = 1; i < 7; i++) begin
            if (vecs[i].exp_fg) vecs[i].exp_rdata = rom_at(vecs[i].faddr);
            else if (vecs[i].exp_lg) vecs[i].exp_rdata = rom_at(vecs[i].laddr);
        end

        // Reset values.
        #12 reset = 1'b1;
        #1;
        check("rst_addr_a", a_pab, 0);
        check("rst_addr_b", b_pab, 0);
        check("rst_gnt_valid", {a_fg, a_lg, a_fv, a_lv, b_fg, b_lg, b_fv, b_lv}, 0);
        check("rst_busy", {a_busy, b_busy}, 0);
        check("rst_state", b_st, ST_IDLE);
        check("rst_rdata", {a_frd, a_lrd}, 0);

        // First grant on the first edge after release.
        b_lreq = 1'b1; b_laddr = 32'h8;
        #1 check("first_gnt", {b_fg, b_lg}, 2'b01);
        @(posedge clk); #1;
        b_lreq = 1'b0;
        check("first_gnt_taken", {b_busy, b_st}, {1'b1, ST_WAIT});

        // Table of isolated transactions on the zero-wait-state instance.
        lf = '0; ll = '0;
        @(posedge clk); #1;
        for (int i = 0; i < 7; i++) begin
            a_freq = vecs[i].freq; a_faddr = vecs[i].faddr;
            a_lreq = vecs[i].lreq; a_laddr = vecs[i].laddr;
            @(negedge clk);
            check("tbl_gnt", {a_fg, a_lg}, {vecs[i].exp_fg, vecs[i].exp_lg});
            @(posedge clk); #1;
            a_freq = 1'b0; a_lreq = 1'b0;
            @(negedge clk);
            check("tbl_valid_early", {a_fv, a_lv}, 2'b00);
            if (vecs[i].exp_fg) check("tbl_addr_bus", a_pab, vecs[i].faddr);
            if (vecs[i].exp_lg) check("tbl_addr_bus", a_pab, vecs[i].laddr);
            @(posedge clk); #1;
            @(negedge clk);
            check("tbl_valid", {a_fv, a_lv}, {vecs[i].exp_fg, vecs[i].exp_lg});
            if (vecs[i].exp_fg) lf = vecs[i].exp_rdata;
            if (vecs[i].exp_lg) ll = vecs[i].exp_rdata;
            check("tbl_fetch_rdata", a_frd, lf);
            check("tbl_ld_rdata", a_lrd, ll);
            check("tbl_busy", a_busy, 0);
            @(posedge clk); #1;
        end

        // Back-to-back fetches 0x0, 0x4, 0x8 with two wait states.
        b_idle(2);
        b_freq = 1'b1; b_faddr = 32'h0;
        ng = 0; nv = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge clk);
            fg_seen = b_fg;
            check("b2b_no_ld_gnt", b_lg, 0);
            if (b_fg) begin
                check("b2b_gnt_cycle", cyc, 3 * ng);
                ng++;
            end
            if (b_fv) begin
                check("b2b_valid_cycle", cyc, 4 + 3 * nv);
                check("b2b_rdata", b_frd, rom[nv]);
                nv++;
            end
            @(posedge clk); #1;
            if (fg_seen) begin
                if (ng < 3) b_faddr = AW'(ng * 4);
                else b_freq = 1'b0;
            end
        end
        check("b2b_gnt_count", ng, 3);
        check("b2b_valid_count", nv, 3);

        // Both requesters held: fetch forced through after every MAX_LD_RUN loads.
        b_idle(2);
        b_freq = 1'b1; b_faddr = 32'h40;
        b_lreq = 1'b1; b_laddr = 32'h80;
        ng = 0;
        for (int cyc = 0; cyc < 60 && ng < 10; cyc++) begin
            @(negedge clk);
            check("both_one_gnt", b_fg && b_lg, 0);
            if (b_fg || b_lg) begin
                ng++;
                check("both_gnt_seq", {b_fg, b_lg}, ((ng % (MAXR + 1)) == 0) ? 2'b10 : 2'b01);
                if (b_fg) check("both_run_at_limit", b_run, MAXR);
            end
            @(posedge clk); #1;
        end
        check("both_gnt_count", ng, 10);

        // Load only: grants every slot and the run never moves.
        b_idle(6);
        b_lreq = 1'b1; b_laddr = 32'h64;
        ng = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (b_lg) ng++;
            if (b_run != 0) check("ld_only_run", b_run, 0);
            @(posedge clk); #1;
        end
        check("ld_only_gnts", ng, (40 + WS_B) / (WS_B + 1));
        check("ld_only_run_end", b_run, 0);

        // Reset clears read data; random run against the reference model.
        b_idle(6);
        @(negedge clk); #1 reset = 1'b0;
        #2 check("rst_rdata_b", {b_frd, b_lrd}, 0);
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #1;
        run = 0; last_g = -100; lf = '0; ll = '0;
        exp_q.delete(); due_q.delete();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            busy_e  = ((c - last_g) >= 1) && ((c - last_g) <= WS_B + 1);
            allowed = (c - last_g) >= WS_B + 1;
            efg = allowed && b_freq && (!b_lreq || run == MAXR);
            elg = allowed && b_lreq && !efg;
            check("rnd_gnt", {b_fg, b_lg}, {efg, elg});
            check("rnd_busy", b_busy, busy_e);
            efv = 1'b0; elv = 1'b0;
            if (due_q.size() > 0 && due_q[0] == c) begin
                void'(due_q.pop_front());
                ent = exp_q.pop_front();
                if (ent[DW]) begin elv = 1'b1; ll = ent[DW-1:0]; end
                else begin efv = 1'b1; lf = ent[DW-1:0]; end
            end
            check("rnd_valid", {b_fv, b_lv}, {efv, elv});
            check("rnd_fetch_rdata", b_frd, lf);
            check("rnd_ld_rdata", b_lrd, ll);
            if (efg || elg) begin
                exp_q.push_back({elg, rom_at(efg ? b_faddr : b_laddr)});
                due_q.push_back(c + WS_B + 2);
                last_g = c;
            end
            if (!b_freq || efg) run = 0;
            else if (elg && run < MAXR) run++;
            fg_seen = b_fg; lg_seen = b_lg;
            quiet = (c >= 380);
            @(posedge clk); #1;
            if (fg_seen) b_freq = 1'b0;
            if (b_freq) begin
                if (c >= 390 || $urandom_range(0, 15) == 0) b_freq = 1'b0;
                else if ($urandom_range(0, 7) == 0) b_faddr = $urandom & 32'hFFFF_FFFC;
            end else if (!quiet && $urandom_range(0, 1) == 1) begin
                b_freq = 1'b1; b_faddr = $urandom & 32'hFFFF_FFFC;
            end
            if (lg_seen) b_lreq = 1'b0;
            if (b_lreq) begin
                if (c >= 390 || $urandom_range(0, 15) == 0) b_lreq = 1'b0;
                else if ($urandom_range(0, 7) == 0) b_laddr = $urandom;
            end else if (!quiet && $urandom_range(0, 2) != 0) begin
                b_lreq = 1'b1; b_laddr = $urandom;
            end
        end
        check("rnd_drained", exp_q.size(), 0);

        // Reset asserted while an access sits in WAIT.
        b_idle(4);
        b_freq = 1'b1; b_faddr = 32'h24;
        @(negedge clk);
        check("rmw_gnt", {b_fg, b_lg}, 2'b10);
        @(posedge clk); #1;
        b_freq = 1'b0;
        @(negedge clk);
        check("rmw_in_wait", b_st, ST_WAIT);
        check("rmw_addr_before", b_pab, 32'h24);
        #1 reset = 1'b0;
        #1;
        check("rmw_state", b_st, ST_IDLE);
        check("rmw_addr", b_pab, 0);
        check("rmw_busy", b_busy, 0);
        @(posedge clk); #2 reset = 1'b1;
        nv = 0;
        repeat (8) begin
            @(negedge clk);
            if (b_fv || b_lv || b_st != ST_IDLE) nv++;
        end
        check("rmw_no_valid_idle", nv, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
